// File: rtl/mem_range_fill_pkg.sv
// Shared types for the range-fill memory: controller states and fill modes.
package mem_range_fill_pkg;

    // Controller state; FILL means the engine owns the RAM port.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Fill value selection, sampled from the mode input at launch.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        CONST = 2'b01,
        INCR  = 2'b10,
        ADDR  = 2'b11
    } fill_mode_e;

endpackage

// File: rtl/mem_range_fill_ram.sv
// Single-port storage array with a registered, read-first read port.
// The array is never reset; only the read register is.
module mem_range_fill_ram #(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; sees the pre-write word on a same-edge collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_range_fill.sv
// RAM with a background range-fill engine. The host loads inclusive
// bounds [low, high] (wrapping through DEPTH-1 -> 0) and a pattern, then
// launches a fill on a rising edge of 'fill'. While busy the engine writes
// one word per cycle and the host port (write, ld_*, fill, read) is locked.
//
// Control protocol: 'fill' is an edge-detected request accepted only when
// busy=0; 'busy' stays high from the launch edge until the edge of the
// last write (or abort); 'done' pulses for exactly one cycle with the last
// write, never on abort. No back-pressure exists beyond busy.
module mem_range_fill
    import mem_range_fill_pkg::*;
#(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ld_low,
    input  logic                 ld_high,
    input  logic                 ld_pat,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] din,
    input  logic                 write,
    input  logic                 fill,
    input  logic [1:0]           mode,
    input  logic                 abort,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH:0]   fill_count,
    output fill_state_e          dbg_state
);

    fill_state_e          state;
    fill_mode_e           mode_r;
    logic [ADDRWIDTH-1:0] low_r;
    logic [ADDRWIDTH-1:0] high_r;
    logic [DATAWIDTH-1:0] pat_r;
    logic [ADDRWIDTH-1:0] cur;
    logic                 fill_q;

    logic                 launch;
    logic [DATAWIDTH-1:0] fill_value;
    logic                 ram_we;
    logic [ADDRWIDTH-1:0] ram_waddr;
    logic [DATAWIDTH-1:0] ram_wdata;
    logic                 ram_re;

    assign launch    = (state == IDLE) && fill && !fill_q;
    assign busy      = (state == FILL);
    assign dbg_state = state;

    // Fill data for the word at 'cur'; offset is the count before increment.
    always_comb begin
        fill_value = '0;
        case (mode_r)
            ZERO:    fill_value = '0;
            CONST:   fill_value = pat_r;
            INCR:    fill_value = pat_r + DATAWIDTH'(fill_count);
            ADDR:    fill_value = DATAWIDTH'(cur);
            default: fill_value = '0;
        endcase
    end

    // RAM port arbitration: the engine owns the port while filling.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr;
        ram_wdata = din;
        ram_re    = 1'b0;
        if (state == FILL) begin
            ram_we    = !abort;
            ram_waddr = cur;
            ram_wdata = fill_value;
        end else begin
            ram_we = write && !launch;
            ram_re = 1'b1;
        end
    end

    // Controller FSM with bound/pattern registers and word counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_r     <= ZERO;
            low_r      <= '0;
            high_r     <= '0;
            pat_r      <= '0;
            cur        <= '0;
            fill_q     <= 1'b0;
            fill_count <= '0;
            done       <= 1'b0;
        end else begin
            fill_q <= fill;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        mode_r     <= fill_mode_e'(mode);
                        cur        <= low_r;
                        fill_count <= '0;
                        state      <= FILL;
                    end else begin
                        if (ld_low)  low_r  <= addr;
                        if (ld_high) high_r <= addr;
                        if (ld_pat)  pat_r  <= din;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        cur        <= cur + 1'b1;
                        fill_count <= fill_count + 1'b1;
                        if (cur == high_r) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_range_fill_ram #(
        .ADDRWIDTH(ADDRWIDTH),
        .DATAWIDTH(DATAWIDTH)
    ) mem_Inst (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (addr),
        .rdata (dout)
    );

endmodule
